dffram_wb_bridge: RTL and testbench

- Wishbone B4 classic slave that sits directly upstream of the 512x32 DFFRAM macro.
- Converts single word/byte-lane bus cycles into the macro's CLK/EN0/WE0/A0/Di0 strobes and returns Do0 with a registered ACK.
- Performs a base/range check and answers any access outside the RAM window with ERR instead of touching the macro.

---
 rtl/dffram_pkg.sv | 21 ++
 rtl/dffram_wb_bridge.sv | 115 +++++++++++
 tb/tb_dffram_wb_bridge.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dffram_pkg.sv
// rtl/dffram_pkg.sv - shared types and sizes for the DFFRAM Wishbone bridge
//
// Contents:
//   DFFRAM_AW     word-address width of the 512x32 macro
//   DFFRAM_DW     data width of the macro
//   DFFRAM_WSIZE  number of byte lanes
//   state_t       bridge FSM state encoding
package dffram_pkg;

  localparam int DFFRAM_AW    = 9;
  localparam int DFFRAM_DW    = 32;
  localparam int DFFRAM_WSIZE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    ACK  = 2'd2,
    ERR  = 2'd3
  } state_t;

endpackage

// File: rtl/dffram_wb_bridge.sv
// rtl/dffram_wb_bridge.sv - Wishbone B4 classic slave in front of the 512x32 DFFRAM macro
//
// Ports:
//   CLK, RST_N            clock shared with the macro, async active-low reset
//   wb_cyc_i/wb_stb_i     bus cycle / strobe
//   wb_we_i, wb_sel_i     write flag and byte-lane selects
//   wb_adr_i, wb_dat_i    byte address and write data
//   wb_dat_o              read data (defined during ACK of a read)
//   wb_ack_o, wb_err_o    normal / out-of-window termination
//   ram_en0, ram_we0      macro enable and byte write enables
//   ram_a0, ram_di0       macro word address and write data
//   ram_do0               macro read data, valid the cycle after an enabled edge
module dffram_wb_bridge
  import dffram_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int          AW        = DFFRAM_AW,
  parameter bit          REG_DOUT  = 1'b0
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  input  logic                    wb_we_i,
  input  logic [DFFRAM_WSIZE-1:0] wb_sel_i,
  input  logic [31:0]             wb_adr_i,
  input  logic [DFFRAM_DW-1:0]    wb_dat_i,
  output logic [DFFRAM_DW-1:0]    wb_dat_o,
  output logic                    wb_ack_o,
  output logic                    wb_err_o,
  output logic                    ram_en0,
  output logic [DFFRAM_WSIZE-1:0] ram_we0,
  output logic [AW-1:0]           ram_a0,
  output logic [DFFRAM_DW-1:0]    ram_di0,
  input  logic [DFFRAM_DW-1:0]    ram_do0
);

  state_t               state;
  state_t               state_nx;
  logic                 req;
  logic                 hit;
  logic [DFFRAM_DW-1:0] dout_q;
  logic                 unused_adr_lsb;

  // Requests are only taken in IDLE, so a strobe held through ACK is
  // served again only after the bubble cycle, never twice in one beat.
  assign req = wb_cyc_i & wb_stb_i & (state == IDLE);
  assign hit = (wb_adr_i[31:AW+2] == ADDR_BASE[31:AW+2]);

  // Byte offset within the word is irrelevant to a word-wide macro.
  assign unused_adr_lsb = ^wb_adr_i[1:0];

  // The macro is driven combinationally so the write, or the read
  // address, lands on the same edge that moves the FSM out of IDLE.
  assign ram_en0 = req & hit;
  assign ram_we0 = (req & hit & wb_we_i) ? wb_sel_i : '0;
  assign ram_a0  = wb_adr_i[AW+1:2];
  assign ram_di0 = wb_dat_i;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (req) begin
          if (!hit) begin
            state_nx = ERR;
          end else if (wb_we_i) begin
            state_nx = ACK;
          end else if (REG_DOUT) begin
            state_nx = RD;
          end else begin
            state_nx = ACK;
          end
        end
      end
      // A master that abandons the cycle while data is still in flight
      // gets no ACK; the captured word is simply discarded.
      RD: begin
        if (!wb_cyc_i) begin
          state_nx = IDLE;
        end else begin
          state_nx = ACK;
        end
      end
      ACK:     state_nx = IDLE;
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Terminations come straight from the state register, so they are
  // glitch-free and mutually exclusive by construction.
  assign wb_ack_o = (state == ACK);
  assign wb_err_o = (state == ERR);

  // Read-data register: only loaded in RD, otherwise holds its last value.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dout_q <= '0;
    end else if (REG_DOUT && (state == RD)) begin
      dout_q <= ram_do0;
    end
  end

  assign wb_dat_o = REG_DOUT ? dout_q : ram_do0;

endmodule

// File: tb/tb_dffram_wb_bridge.sv
// tb/tb_dffram_wb_bridge.sv - self-checking bench for dffram_wb_bridge (REG_DOUT 0 and 1)
module tb_dffram_wb_bridge;

  localparam logic [31:0] BASE = 32'h3000_0800;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cyc_i [2];
  logic        stb_i [2];
  logic        we_i  [2];
  logic [3:0]  sel_i [2];
  logic [31:0] adr_i [2];
  logic [31:0] dat_i [2];
  logic [31:0] dat_o [2];
  logic        ack_o [2];
  logic        err_o [2];
  logic        en0   [2];
  logic [3:0]  we0   [2];
  logic [8:0]  a0    [2];
  logic [31:0] di0   [2];
  logic [31:0] do0   [2];

  // Macro behaviour: synchronous, byte-writable, Do0 updated on enabled edges.
  logic [31:0] ram [2][512];
  // Reference memory: what each RAM must contain after the bus writes so far.
  logic [31:0] mdl [2][512];

  // Expected events, keyed by cycle*2 + dut.
  bit          e_ack [int];
  bit          e_err [int];
  bit          e_en  [int];
  logic [3:0]  e_we  [int];
  logic [8:0]  e_a   [int];
  logic [31:0] e_dat [int];

  int cyc_n = 0;
  int nchk = 0;
  int errs = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  dffram_wb_bridge #(.ADDR_BASE(BASE), .AW(9), .REG_DOUT(1'b0)) u_dut0 (
    .CLK(clk), .RST_N(rst_n),
    .wb_cyc_i(cyc_i[0]), .wb_stb_i(stb_i[0]), .wb_we_i(we_i[0]), .wb_sel_i(sel_i[0]),
    .wb_adr_i(adr_i[0]), .wb_dat_i(dat_i[0]), .wb_dat_o(dat_o[0]),
    .wb_ack_o(ack_o[0]), .wb_err_o(err_o[0]),
    .ram_en0(en0[0]), .ram_we0(we0[0]), .ram_a0(a0[0]), .ram_di0(di0[0]), .ram_do0(do0[0])
  );

  dffram_wb_bridge #(.ADDR_BASE(BASE), .AW(9), .REG_DOUT(1'b1)) u_dut1 (
    .CLK(clk), .RST_N(rst_n),
    .wb_cyc_i(cyc_i[1]), .wb_stb_i(stb_i[1]), .wb_we_i(we_i[1]), .wb_sel_i(sel_i[1]),
    .wb_adr_i(adr_i[1]), .wb_dat_i(dat_i[1]), .wb_dat_o(dat_o[1]),
    .wb_ack_o(ack_o[1]), .wb_err_o(err_o[1]),
    .ram_en0(en0[1]), .ram_we0(we0[1]), .ram_a0(a0[1]), .ram_di0(di0[1]), .ram_do0(do0[1])
  );

  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    for (int d = 0; d < 2; d++) begin
      if (en0[d]) begin
        for (int b = 0; b < 4; b++)
          if (we0[d][b]) ram[d][a0[d]][8*b +: 8] <= di0[d][8*b +: 8];
        do0[d] <= ram[d][a0[d]];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // Compare process: every cycle, every DUT, on the falling edge.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int d = 0; d < 2; d++) begin
        int k;
        k = cyc_n * 2 + d;
        chk($sformatf("ack[%0d]", d), {31'd0, ack_o[d]}, {31'd0, e_ack.exists(k)});
        chk($sformatf("err[%0d]", d), {31'd0, err_o[d]}, {31'd0, e_err.exists(k)});
        chk($sformatf("en0[%0d]", d), {31'd0, en0[d]}, {31'd0, e_en.exists(k)});
        if (e_en.exists(k)) begin
          chk($sformatf("we0[%0d]", d), {28'd0, we0[d]}, {28'd0, e_we[k]});
          chk($sformatf("a0[%0d]", d), {23'd0, a0[d]}, {23'd0, e_a[k]});
        end else begin
          chk($sformatf("we0_idle[%0d]", d), {28'd0, we0[d]}, 32'd0);
        end
        if (e_dat.exists(k)) chk($sformatf("dat_o[%0d]", d), dat_o[d], e_dat[k]);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic bit in_win(input logic [31:0] a);
    return a[31:11] == BASE[31:11];
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] v,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = v[8*b +: 8];
    return r;
  endfunction

  // One classic cycle: request now, master drops stb right after the termination.
  task automatic xact(input int d, input bit w, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] v, output logic [31:0] rd);
    int c;
    int lat;
    int k;
    logic [8:0] idx;
    c = cyc_n;
    idx = a[10:2];
    cyc_i[d] = 1'b1; stb_i[d] = 1'b1; we_i[d] = w;
    sel_i[d] = s; adr_i[d] = a; dat_i[d] = v;
    lat = (in_win(a) && !w && d == 1) ? 2 : 1;
    k = (c + lat) * 2 + d;
    if (!in_win(a)) begin
      e_err[k] = 1'b1;
    end else begin
      e_en[c*2+d] = 1'b1;
      e_we[c*2+d] = w ? s : 4'h0;
      e_a[c*2+d] = idx;
      e_ack[k] = 1'b1;
      if (w) mdl[d][idx] = merge(mdl[d][idx], v, s);
      else e_dat[k] = mdl[d][idx];
    end
    repeat (lat) tick;
    rd = dat_o[d];
    tick;
    cyc_i[d] = 1'b0; stb_i[d] = 1'b0; we_i[d] = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    int c;
    int d;
    int k;
    logic [31:0] a;
    for (int i = 0; i < 2; i++) begin
      cyc_i[i] = 0; stb_i[i] = 0; we_i[i] = 0; sel_i[i] = 0;
      adr_i[i] = 0; dat_i[i] = 0; do0[i] = 0;
      for (int j = 0; j < 512; j++) begin
        ram[i][j] = 32'd0;
        mdl[i][j] = 32'd0;
      end
    end
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("reset_ack", {31'd0, ack_o[i]}, 32'd0);
      chk("reset_err", {31'd0, err_o[i]}, 32'd0);
      chk("reset_en", {31'd0, en0[i]}, 32'd0);
      chk("reset_we", {28'd0, we0[i]}, 32'd0);
    end
    chk("reset_dout1", dat_o[1], 32'd0);
    rst_n = 1'b1;
    chk_on = 1'b1;
    tick;

    for (d = 0; d < 2; d++) begin
      xact(d, 1, BASE + 32'h10, 4'hF, 32'hDEADBEEF, rd);
      xact(d, 0, BASE + 32'h10, 4'h0, 32'h0, rd);
      chk("full_rw", rd, 32'hDEADBEEF);
      xact(d, 1, BASE + 32'h10, 4'h1, 32'h0000_0055, rd);
      xact(d, 0, BASE + 32'h10, 4'h0, 32'h0, rd);
      chk("lane0", rd, 32'hDEADBE55);
      xact(d, 1, BASE + 32'h10, 4'h0, 32'hFFFF_FFFF, rd);
      xact(d, 0, BASE + 32'h10, 4'h0, 32'h0, rd);
      chk("sel0_nochange", rd, 32'hDEADBE55);
      chk("model_pin", mdl[d][4], 32'hDEADBE55);
      xact(d, 1, BASE, 4'hF, 32'hA5A5_0001, rd);
      xact(d, 1, BASE + 32'h7FC, 4'hF, 32'h5A5A_01FF, rd);
      xact(d, 0, BASE, 4'hF, 32'h0, rd);
      chk("word0", rd, 32'hA5A5_0001);
      xact(d, 0, BASE + 32'h7FC, 4'hF, 32'h0, rd);
      chk("word511", rd, 32'h5A5A_01FF);
      xact(d, 1, BASE + 32'h800, 4'hF, 32'h1234_5678, rd);
      xact(d, 0, BASE - 32'h4, 4'hF, 32'h0, rd);
      xact(d, 0, BASE, 4'hF, 32'h0, rd);
      chk("no_alias", rd, 32'hA5A5_0001);

      // Held strobe across four cycles: two writes, bubble between them.
      c = cyc_n;
      cyc_i[d] = 1; stb_i[d] = 1; we_i[d] = 1; sel_i[d] = 4'hF;
      adr_i[d] = BASE + 32'h20; dat_i[d] = 32'hCAFE_0008;
      for (int j = 0; j < 4; j += 2) begin
        e_en[(c+j)*2+d] = 1'b1;
        e_we[(c+j)*2+d] = 4'hF;
        e_a[(c+j)*2+d] = 9'd8;
        e_ack[(c+j+1)*2+d] = 1'b1;
      end
      mdl[d][8] = 32'hCAFE_0008;
      repeat (4) tick;
      cyc_i[d] = 0; stb_i[d] = 0; we_i[d] = 0;
      xact(d, 0, BASE + 32'h20, 4'hF, 32'h0, rd);
      chk("held_data", rd, 32'hCAFE_0008);
    end

    // Reset pulse entirely between two edges while DUT1 sits in RD.
    c = cyc_n;
    cyc_i[1] = 1; stb_i[1] = 1; we_i[1] = 0; adr_i[1] = BASE + 32'h10;
    e_en[c*2+1] = 1'b1; e_we[c*2+1] = 4'h0; e_a[c*2+1] = 9'd4;
    tick;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_ack", {31'd0, ack_o[1]}, 32'd0);
    chk("rst_mid_dout", dat_o[1], 32'd0);
    cyc_i[1] = 0; stb_i[1] = 0;
    #3 rst_n = 1'b1;
    tick;
    xact(1, 0, BASE + 32'h10, 4'hF, 32'h0, rd);
    chk("after_reset_read", rd, 32'hDEADBE55);

    // Abort: cyc dropped in RD, new request accepted the very next cycle.
    c = cyc_n;
    cyc_i[1] = 1; stb_i[1] = 1; we_i[1] = 0; adr_i[1] = BASE + 32'h7FC;
    e_en[c*2+1] = 1'b1; e_we[c*2+1] = 4'h0; e_a[c*2+1] = 9'd511;
    tick;
    cyc_i[1] = 0; stb_i[1] = 0;
    tick;
    xact(1, 0, BASE, 4'hF, 32'h0, rd);
    chk("after_abort_read", rd, 32'hA5A5_0001);

    // Randomized traffic against the reference memory.
    for (int i = 0; i < 400; i++) begin
      d = $urandom_range(0, 1);
      k = $urandom_range(0, 9);
      if (k == 0) a = $urandom;
      else a = BASE + ($urandom_range(0, 511) << 2) + $urandom_range(0, 3);
      xact(d, 1'($urandom_range(0, 1)), a, 4'($urandom), $urandom, rd);
      repeat ($urandom_range(0, 2)) tick;
    end

    repeat (3) tick;
    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
